// File: rtl/lw_sha2_mctx_core.sv
// ----------------------------------------------------------------------------
// lw_sha2_mctx_core
//
// Iterative SHA-2 compression engine. It runs one round per clock and takes
// one message word per clock. It keeps N_CTX independent chaining-value
// contexts, so blocks from several messages can be interleaved on one engine.
// WORD_W=32 builds the SHA-256/224 engine (64 rounds). WORD_W=64 builds the
// SHA-512/384/512-256/512-224 engine (80 rounds). Messages arrive already
// padded.
//
// Ports
//   clk_i, aresetn_i   clock, asynchronous active-low reset
//   start_i            begin a block (taken only while core_ready_o=1)
//   ctx_i              context index for the block, sampled with start_i
//   new_i              1: load the standard IV for opcode_i, 0: continue context
//   opcode_i           0: SHA-256/512, 1: SHA-224/384, 2: 512/256, 3: 512/224
//   abort_i            drop the block in flight, no write-back, no digest
//   data_valid_i/data_i/last_i   message word stream (W0 first)
//   data_ready_o       a word is consumed this cycle when valid
//   core_ready_o       engine idle
//   hash_o/done_o/done_ctx_o     truncated digest, one-cycle strobe, context
// ----------------------------------------------------------------------------
module lw_sha2_mctx_core #(
    parameter int WORD_W  = 32,
    parameter int N_CTX   = 4,
    localparam int CTX_W  = (N_CTX > 1) ? $clog2(N_CTX) : 1
) (
    input  logic                         clk_i,
    input  logic                         aresetn_i,
    input  logic                         start_i,
    input  logic [CTX_W-1:0]             ctx_i,
    input  logic                         new_i,
    input  logic [1:0]                   opcode_i,
    input  logic                         abort_i,
    input  logic                         data_valid_i,
    input  logic [WORD_W-1:0]            data_i,
    input  logic                         last_i,
    output logic                         data_ready_o,
    output logic                         core_ready_o,
    output logic [7:0][WORD_W-1:0]       hash_o,
    output logic                         done_o,
    output logic [CTX_W-1:0]             done_ctx_o
);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
        $fatal(1, "lw_sha2_mctx_core: WORD_W must be 32 or 64");
    end
    if (N_CTX < 1 || N_CTX > 16) begin : g_bad_n_ctx
        $fatal(1, "lw_sha2_mctx_core: N_CTX must be in 1..16");
    end

    localparam int         ROUNDS     = (WORD_W == 64) ? 80 : 64;
    localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);

    // SHA-256 round constants and IVs are the upper 32 bits of the SHA-512
    // ones (same cube/square roots). SHA-224 IVs are the lower 32 bits of
    // the SHA-384 IVs. So one set of 64-bit tables serves both widths.
    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };
    localparam logic [63:0] IV512 [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };
    localparam logic [63:0] IV384 [8] = '{
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };
    localparam logic [63:0] IV512_256 [8] = '{
        64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2, 64'h2393b86b6f53b151, 64'h963877195940eabd,
        64'h96283ee2a88effe3, 64'hbe5e1e2553863992, 64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2
    };
    localparam logic [63:0] IV512_224 [8] = '{
        64'h8c3d37c819544da2, 64'h73e1996689dcd4d6, 64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf,
        64'h0f6d2b697bd44da8, 64'h77e36f7304c48942, 64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1
    };

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_FINAL} state_t;
    typedef logic [7:0][WORD_W-1:0] hvec_t;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
        if (WORD_W == 64) return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
        else              return rotr(x, 2)  ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
        if (WORD_W == 64) return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
        else              return rotr(x, 6)  ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
        if (WORD_W == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
        else              return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
        if (WORD_W == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
        else              return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic hvec_t iv_of(input logic [1:0] mode);
        hvec_t v;
        for (int i = 0; i < 8; i++) begin
            if (WORD_W == 64) begin
                case (mode)
                    2'd0:    v[i] = IV512[i][WORD_W-1:0];
                    2'd1:    v[i] = IV384[i][WORD_W-1:0];
                    2'd2:    v[i] = IV512_256[i][WORD_W-1:0];
                    default: v[i] = IV512_224[i][WORD_W-1:0];
                endcase
            end else begin
                v[i] = mode[0] ? IV384[i][WORD_W-1:0] : IV512[i][63 -: WORD_W];
            end
        end
        return v;
    endfunction

    // Truncated variants only mask the readout; the full state is still
    // what gets chained between blocks.
    function automatic hvec_t truncate(input hvec_t h, input logic [1:0] mode);
        hvec_t v;
        v = h;
        if (WORD_W == 64) begin
            case (mode)
                2'd1: v[7:6] = '0;
                2'd2: v[7:4] = '0;
                2'd3: begin
                    v[7:4]       = '0;
                    v[3][31:0]   = '0;
                end
                default: ;
            endcase
        end else if (mode == 2'd1) begin
            v[7] = '0;
        end
        return v;
    endfunction

    state_t               state_q, state_d;
    logic [6:0]           round_q, round_d;
    logic [CTX_W-1:0]     ctx_q, ctx_d;
    logic [1:0]           mode_q, mode_d;
    logic                 last_q, last_d;
    hvec_t                work_q, work_d;       // a..h at index 0..7
    hvec_t                chain_q, chain_d;
    logic [15:0][WORD_W-1:0] wbuf_q, wbuf_d;    // circular W[t mod 16]
    hvec_t                hash_q, hash_d;
    logic                 done_q, done_d;
    logic [CTX_W-1:0]     done_ctx_q, done_ctx_d;
    hvec_t                ctx_chain_q [N_CTX];
    hvec_t                ctx_chain_d [N_CTX];
    logic [1:0]           ctx_mode_q [N_CTX];
    logic [1:0]           ctx_mode_d [N_CTX];

    // Round datapath
    logic [3:0]           idx_0, idx_1, idx_9, idx_14;
    logic [WORD_W-1:0]    w_exp, w_t, k_t, t1, t2;
    hvec_t                round_state, h_sum;

    always_comb begin
        idx_0  = round_q[3:0];
        idx_1  = round_q[3:0] + 4'd1;
        idx_9  = round_q[3:0] + 4'd9;
        idx_14 = round_q[3:0] + 4'd14;
        // Slots t-16, t-15, t-7 and t-2 of the 16-entry ring, in that order.
        w_exp  = ssig1(wbuf_q[idx_14]) + wbuf_q[idx_9] + ssig0(wbuf_q[idx_1]) + wbuf_q[idx_0];
        // During LOAD the round consumes the incoming word directly.
        w_t    = (state_q == S_LOAD) ? data_i : w_exp;
        k_t    = K512[round_q][63 -: WORD_W];
        t1     = work_q[7] + bsig1(work_q[4])
               + ((work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6])) + k_t + w_t;
        t2     = bsig0(work_q[0])
               + ((work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]));
        round_state[0] = t1 + t2;
        round_state[1] = work_q[0];
        round_state[2] = work_q[1];
        round_state[3] = work_q[2];
        round_state[4] = work_q[3] + t1;
        round_state[5] = work_q[4];
        round_state[6] = work_q[5];
        round_state[7] = work_q[6];
        for (int i = 0; i < 8; i++) h_sum[i] = chain_q[i] + work_q[i];
    end

    // Control and next-state
    logic       start_legal;
    hvec_t      sel_chain;
    logic [1:0] sel_mode;

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        round_d     = round_q;
        ctx_d       = ctx_q;
        mode_d      = mode_q;
        last_d      = last_q;
        work_d      = work_q;
        chain_d     = chain_q;
        wbuf_d      = wbuf_q;
        hash_d      = hash_q;
        done_d      = 1'b0;
        done_ctx_d  = done_ctx_q;
        ctx_chain_d = ctx_chain_q;
        ctx_mode_d  = ctx_mode_q;
        sel_chain   = '0;
        sel_mode    = '0;

        for (int i = 0; i < N_CTX; i++) begin
            if (int'(ctx_i) == i) begin
                sel_chain = ctx_chain_q[i];
                sel_mode  = ctx_mode_q[i];
            end
        end
        start_legal = (int'(ctx_i) < N_CTX) && (!new_i || (WORD_W == 64) || !opcode_i[1]);

        unique case (state_q)
            S_IDLE: begin
                if (start_i && start_legal) begin
                    ctx_d   = ctx_i;
                    last_d  = 1'b0;
                    round_d = '0;
                    state_d = S_LOAD;
                    if (new_i) begin
                        mode_d  = opcode_i;
                        work_d  = iv_of(opcode_i);
                        chain_d = iv_of(opcode_i);
                        for (int i = 0; i < N_CTX; i++)
                            if (int'(ctx_i) == i) ctx_mode_d[i] = opcode_i;
                    end else begin
                        mode_d  = sel_mode;
                        work_d  = sel_chain;
                        chain_d = sel_chain;
                    end
                end
            end
            S_LOAD: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (data_valid_i) begin
                    work_d         = round_state;
                    wbuf_d[idx_0]  = data_i;
                    last_d         = last_q | last_i;
                    round_d        = round_q + 7'd1;
                    if (round_q == 7'd15) state_d = S_EXPAND;
                end
            end
            S_EXPAND: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    work_d        = round_state;
                    wbuf_d[idx_0] = w_exp;
                    round_d       = round_q + 7'd1;
                    if (round_q == LAST_ROUND) state_d = S_FINAL;
                end
            end
            S_FINAL: begin
                state_d = S_IDLE;
                if (!abort_i) begin
                    if (last_q) begin
                        hash_d     = truncate(h_sum, mode_q);
                        done_d     = 1'b1;
                        done_ctx_d = ctx_q;
                        // The message is finished: the context is released.
                        for (int i = 0; i < N_CTX; i++) begin
                            if (int'(ctx_q) == i) begin
                                ctx_chain_d[i] = '0;
                                ctx_mode_d[i]  = '0;
                            end
                        end
                    end else begin
                        for (int i = 0; i < N_CTX; i++)
                            if (int'(ctx_q) == i) ctx_chain_d[i] = h_sum;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q    <= S_IDLE;
            round_q    <= '0;
            ctx_q      <= '0;
            mode_q     <= '0;
            last_q     <= 1'b0;
            work_q     <= '0;
            chain_q    <= '0;
            wbuf_q     <= '0;
            hash_q     <= '0;
            done_q     <= 1'b0;
            done_ctx_q <= '0;
            // NOTE: the context store is reset too, because a reset must discard every stored chain and mode tag.
            for (int i = 0; i < N_CTX; i++) begin
                ctx_chain_q[i] <= '0;
                ctx_mode_q[i]  <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            round_q     <= round_d;
            ctx_q       <= ctx_d;
            mode_q      <= mode_d;
            last_q      <= last_d;
            work_q      <= work_d;
            chain_q     <= chain_d;
            wbuf_q      <= wbuf_d;
            hash_q      <= hash_d;
            done_q      <= done_d;
            done_ctx_q  <= done_ctx_d;
            ctx_chain_q <= ctx_chain_d;
            ctx_mode_q  <= ctx_mode_d;
        end
    end

    assign core_ready_o = (state_q == S_IDLE);
    assign data_ready_o = (state_q == S_LOAD);
    assign hash_o       = hash_q;
    assign done_o       = done_q;
    assign done_ctx_o   = done_ctx_q;

endmodule

// File: tb/tb_lw_sha2_mctx_core.sv
// ----------------------------------------------------------------------------
// tb_lw_sha2_mctx_core
//
// Two engines share the stimulus bus: a SHA-256 engine with three contexts
// and a SHA-512 engine with four. Expected digests go into a per-engine
// queue when a final block is started. A monitor pops an entry on every
// done_o pulse and compares against it.
// ----------------------------------------------------------------------------
module tb_lw_sha2_mctx_core;

    typedef logic [7:0][63:0] hash_t;
    typedef logic [63:0] blk_t [16];
    typedef struct { hash_t hash; logic [1:0] ctx; } sb_t;
    typedef struct { string name; bit sel64; logic [1:0] opc; logic [1:0] ctx; hash_t exp; } vec_t;

    logic clk = 1'b0;
    logic aresetn;
    logic start32, start64, new_b, abort_b, dv, last_b;
    logic [1:0]  ctx_b, opc_b;
    logic [63:0] data_b;

    logic dr32, cr32, done32, dr64, cr64, done64;
    logic [1:0] dctx32, dctx64;
    logic [7:0][31:0] hash32;
    logic [7:0][63:0] hash64;

    int n_checks = 0;
    int n_errors = 0;
    sb_t sb32[$];
    sb_t sb64[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    lw_sha2_mctx_core #(.WORD_W(32), .N_CTX(3)) dut32 (
        .clk_i(clk), .aresetn_i(aresetn), .start_i(start32), .ctx_i(ctx_b), .new_i(new_b),
        .opcode_i(opc_b), .abort_i(abort_b), .data_valid_i(dv), .data_i(data_b[31:0]),
        .last_i(last_b), .data_ready_o(dr32), .core_ready_o(cr32), .hash_o(hash32),
        .done_o(done32), .done_ctx_o(dctx32)
    );

    lw_sha2_mctx_core #(.WORD_W(64), .N_CTX(4)) dut64 (
        .clk_i(clk), .aresetn_i(aresetn), .start_i(start64), .ctx_i(ctx_b), .new_i(new_b),
        .opcode_i(opc_b), .abort_i(abort_b), .data_valid_i(dv), .data_i(data_b),
        .last_i(last_b), .data_ready_o(dr64), .core_ready_o(cr64), .hash_o(hash64),
        .done_o(done64), .done_ctx_o(dctx64)
    );

    function automatic hash_t mk(input logic [63:0] h0, h1, h2, h3, h4, h5, h6, h7);
        hash_t v;
        v[0] = h0; v[1] = h1; v[2] = h2; v[3] = h3;
        v[4] = h4; v[5] = h5; v[6] = h6; v[7] = h7;
        return v;
    endfunction

    function automatic hash_t widen32(input logic [7:0][31:0] h);
        hash_t v;
        for (int i = 0; i < 8; i++) v[i] = {32'h0, h[i]};
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_hash(input string name, input hash_t act, input hash_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done32 === 1'b1) begin
            if (sb32.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL done32_unexpected: got done_o=1, expected no pulse");
            end else begin
                sb_t e;
                e = sb32.pop_front();
                check_hash("digest32", widen32(hash32), e.hash);
                check("done_ctx32", 64'(dctx32), 64'(e.ctx));
            end
        end
        if (done64 === 1'b1) begin
            if (sb64.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL done64_unexpected: got done_o=1, expected no pulse");
            end else begin
                sb_t e;
                e = sb64.pop_front();
                check_hash("digest64", hash64, e.hash);
                check("done_ctx64", 64'(dctx64), 64'(e.ctx));
            end
        end
    end

    // Run one block. stall_at>=0 drops data_valid_i for 5 cycles before that
    // word; abort_at>=0 raises abort_i so that edge number abort_at+1 sees it.
    task automatic run_block(input string name, input bit sel64, input logic [1:0] c,
                             input bit nw, input logic [1:0] opc, input bit lst,
                             input blk_t blk, input int stall_at, input int abort_at,
                             input bit exp_done);
        int edges;
        int exp_lat;
        bit aborted;
        exp_lat = (sel64 ? 81 : 65) + ((stall_at >= 0) ? 5 : 0);
        @(negedge clk);
        ctx_b = c; new_b = nw; opc_b = opc;
        if (sel64) start64 = 1'b1; else start32 = 1'b1;
        @(posedge clk);
        edges = 0;
        @(negedge clk);
        start32 = 1'b0; start64 = 1'b0;
        check({name, "_data_ready_load"}, 64'(sel64 ? dr64 : dr32), 64'd1);
        for (int i = 0; i < 16; i++) begin
            if (i == stall_at) begin
                dv = 1'b0;
                repeat (5) begin
                    @(posedge clk); edges++;
                    @(negedge clk);
                end
            end
            dv = 1'b1; data_b = blk[i]; last_b = lst;
            @(posedge clk); edges++;
            @(negedge clk);
        end
        dv = 1'b0; last_b = 1'b0;
        check({name, "_data_ready_expand"}, 64'(sel64 ? dr64 : dr32), 64'd0);
        aborted = 1'b0;
        while (!(sel64 ? cr64 : cr32) && edges < 200) begin
            if (edges == abort_at) begin
                abort_b = 1'b1;
                aborted = 1'b1;
            end
            @(posedge clk); edges++;
            @(negedge clk);
            abort_b = 1'b0;
        end
        if (aborted) begin
            check({name, "_abort_ready"}, 64'(sel64 ? cr64 : cr32), 64'd1);
            check({name, "_abort_done"}, 64'(sel64 ? done64 : done32), 64'd0);
        end else begin
            check({name, "_latency"}, 64'(edges), 64'(exp_lat));
            check({name, "_done"}, 64'(sel64 ? done64 : done32), 64'(exp_done));
        end
    endtask

    task automatic illegal_start(input string name, input logic [1:0] c, input logic [1:0] opc);
        @(negedge clk);
        ctx_b = c; new_b = 1'b1; opc_b = opc; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        check({name, "_core_ready"}, 64'(cr32), 64'd1);
        check({name, "_data_ready"}, 64'(dr32), 64'd0);
    endtask

    blk_t abc32, abc64, m1_32, m2_32;
    hash_t h_abc256, h_2blk;

    initial begin
        aresetn = 1'b0;
        start32 = 1'b0; start64 = 1'b0; new_b = 1'b0; abort_b = 1'b0;
        dv = 1'b0; last_b = 1'b0; ctx_b = '0; opc_b = '0; data_b = '0;

        for (int i = 0; i < 16; i++) begin
            abc32[i] = '0; abc64[i] = '0; m1_32[i] = '0; m2_32[i] = '0;
        end
        abc32[0] = 64'h61626380;          abc32[15] = 64'h18;
        abc64[0] = 64'h6162638000000000;  abc64[15] = 64'h18;
        m1_32[0]  = 64'h61626364; m1_32[1]  = 64'h62636465; m1_32[2]  = 64'h63646566;
        m1_32[3]  = 64'h64656667; m1_32[4]  = 64'h65666768; m1_32[5]  = 64'h66676869;
        m1_32[6]  = 64'h6768696a; m1_32[7]  = 64'h68696a6b; m1_32[8]  = 64'h696a6b6c;
        m1_32[9]  = 64'h6a6b6c6d; m1_32[10] = 64'h6b6c6d6e; m1_32[11] = 64'h6c6d6e6f;
        m1_32[12] = 64'h6d6e6f70; m1_32[13] = 64'h6e6f7071; m1_32[14] = 64'h80000000;
        m2_32[15] = 64'h1c0;

        h_abc256 = mk(64'hba7816bf, 64'h8f01cfea, 64'h414140de, 64'h5dae2223,
                      64'hb00361a3, 64'h96177a9c, 64'hb410ff61, 64'hf20015ad);
        h_2blk   = mk(64'h248d6a61, 64'hd20638b8, 64'he5c02693, 64'h0c3e6039,
                      64'ha33ce459, 64'h64ff2167, 64'hf6ecedd4, 64'h19db06c1);

        vecs.push_back('{"abc_sha256", 1'b0, 2'd0, 2'd0, h_abc256});
        vecs.push_back('{"abc_sha224", 1'b0, 2'd1, 2'd0,
            mk(64'h23097d22, 64'h3405d822, 64'h8642a477, 64'hbda255b3,
               64'h2aadbce4, 64'hbda0b3f7, 64'he36c9da7, 64'h0)});
        vecs.push_back('{"abc_sha512", 1'b1, 2'd0, 2'd3,
            mk(64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
               64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f)});
        vecs.push_back('{"abc_sha384", 1'b1, 2'd1, 2'd0,
            mk(64'hcb00753f45a35e8b, 64'hb5a03d699ac65007, 64'h272c32ab0eded163, 64'h1a8b605a43ff5bed,
               64'h8086072ba1e7cc23, 64'h58baeca134c825a7, 64'h0, 64'h0)});
        vecs.push_back('{"abc_sha512_256", 1'b1, 2'd2, 2'd1,
            mk(64'h53048e2681941ef9, 64'h9b2e29b76b4c7dab, 64'he4c2d0c634fc6d46, 64'he0e2f13107e7af23,
               64'h0, 64'h0, 64'h0, 64'h0)});
        vecs.push_back('{"abc_sha512_224", 1'b1, 2'd3, 2'd2,
            mk(64'h4634270f707b6a54, 64'hdaae7530460842e2, 64'h0e37ed265ceee9a4, 64'h3e8924aa00000000,
               64'h0, 64'h0, 64'h0, 64'h0)});

        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        check("rst_core_ready32", 64'(cr32), 64'd1);
        check("rst_data_ready32", 64'(dr32), 64'd0);
        check("rst_done32", 64'(done32), 64'd0);
        check_hash("rst_hash32", widen32(hash32), '0);
        check("rst_core_ready64", 64'(cr64), 64'd1);
        check("rst_done_ctx64", 64'(dctx64), 64'd0);

        // Single-block vectors, every mode of both engines.
        for (int v = 0; v < vecs.size(); v++) begin
            if (vecs[v].sel64) begin
                sb64.push_back('{vecs[v].exp, vecs[v].ctx});
                run_block(vecs[v].name, 1'b1, vecs[v].ctx, 1'b1, vecs[v].opc, 1'b1, abc64, -1, -1, 1'b1);
            end else begin
                sb32.push_back('{vecs[v].exp, vecs[v].ctx});
                run_block(vecs[v].name, 1'b0, vecs[v].ctx, 1'b1, vecs[v].opc, 1'b1, abc32, -1, -1, 1'b1);
            end
        end

        // Two messages interleaved on one engine.
        run_block("ilv_blk1_ctx2", 1'b0, 2'd2, 1'b1, 2'd0, 1'b0, m1_32, -1, -1, 1'b0);
        sb32.push_back('{h_abc256, 2'd1});
        run_block("ilv_abc_ctx1", 1'b0, 2'd1, 1'b1, 2'd0, 1'b1, abc32, -1, -1, 1'b1);
        sb32.push_back('{h_2blk, 2'd2});
        run_block("ilv_blk2_ctx2", 1'b0, 2'd2, 1'b0, 2'd3, 1'b1, m2_32, -1, -1, 1'b1);

        // Five-cycle stall in the middle of LOAD.
        sb32.push_back('{h_abc256, 2'd1});
        run_block("stall_abc", 1'b0, 2'd1, 1'b1, 2'd0, 1'b1, abc32, 7, -1, 1'b1);

        // Abort in EXPAND leaves the stored chain untouched.
        run_block("abt_blk1", 1'b0, 2'd2, 1'b1, 2'd0, 1'b0, m1_32, -1, -1, 1'b0);
        run_block("abt_blk2", 1'b0, 2'd2, 1'b0, 2'd0, 1'b0, m2_32, -1, 40, 1'b0);
        repeat (70) @(negedge clk);
        sb32.push_back('{h_2blk, 2'd2});
        run_block("abt_resume", 1'b0, 2'd2, 1'b0, 2'd0, 1'b1, m2_32, -1, -1, 1'b1);

        // Rejected starts, then a continuation whose opcode must be ignored.
        illegal_start("ill_op2", 2'd0, 2'd2);
        illegal_start("ill_op3", 2'd1, 2'd3);
        illegal_start("ill_ctx3", 2'd3, 2'd0);
        @(negedge clk);
        ctx_b = 2'd0; new_b = 1'b0; opc_b = 2'd2; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        check("cont_op_ignored_busy", 64'(cr32), 64'd0);
        abort_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort_b = 1'b0;
        check("cont_abort_idle", 64'(cr32), 64'd1);

        // Asynchronous reset in the middle of EXPAND.
        @(negedge clk);
        ctx_b = 2'd0; new_b = 1'b1; opc_b = 2'd0; start32 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start32 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dv = 1'b1; data_b = abc32[i]; last_b = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        dv = 1'b0; last_b = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("mid_expand_busy", 64'(cr32), 64'd0);
        aresetn = 1'b0;
        #2;
        check("arst_core_ready", 64'(cr32), 64'd1);
        check("arst_data_ready", 64'(dr32), 64'd0);
        check("arst_done", 64'(done32), 64'd0);
        check("arst_done_ctx", 64'(dctx32), 64'd0);
        check_hash("arst_hash", widen32(hash32), '0);
        @(negedge clk);
        aresetn = 1'b1;
        repeat (80) @(negedge clk);

        check("sb32_drained", 64'(sb32.size()), 64'd0);
        check("sb64_drained", 64'(sb64.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lw_sha2_mctx_core.md
Name: lw_sha2_mctx_core

Overview:
Parametrised successor to the lightweight SHA-2 round core. One engine is built at either 32-bit word width (SHA-256/224) or 64-bit word width (SHA-512/384/512-256/512-224). It performs one round per clock and accepts one message word per clock. It holds N_CTX independent chaining-value contexts, so blocks from several messages can be interleaved on a single engine. It sits between the bus/DMA word feeder and the digest readout; message padding is done upstream.

Parameters:
WORD_W, 32, word width; 32 selects the SHA-256 family (R=64 rounds), 64 selects the SHA-512 family (R=80 rounds); any other value is a fatal elaboration error.
N_CTX, 4, number of independent hash contexts, 1..16.
CTX_W, max(1,$clog2(N_CTX)), width of the context index (derived; not to be overridden).

Ports:
clk_i  in  1  clock.
aresetn_i  in  1  asynchronous active-low reset.
start_i  in  1  begin a block; accepted only when core_ready_o=1.
ctx_i  in  CTX_W  context used by the block; sampled with start_i.
new_i  in  1  sampled with start_i; 1 = load the standard IV for opcode_i, 0 = continue from the stored context value.
opcode_i  in  2  sampled with start_i when new_i=1; 0=SHA-256/512, 1=SHA-224/384, 2=SHA-512/256, 3=SHA-512/224 (2 and 3 are valid only when WORD_W=64).
abort_i  in  1  cancel the current block.
data_valid_i  in  1  message word valid.
data_i  in  WORD_W  message word, big-endian word order (W0 first).
last_i  in  1  final block of the message; sampled on every accepted word.
data_ready_o  out  1  engine accepts a word this cycle.
core_ready_o  out  1  engine idle and able to accept start_i.
hash_o  out  8xWORD_W  digest, hash_o[0]=H0.
done_o  out  1  one-cycle pulse; hash_o is valid.
done_ctx_o  out  CTX_W  context index of the digest on hash_o.

Behaviour:
- Reset values: core_ready_o=1, data_ready_o=0, done_o=0, hash_o=0, done_ctx_o=0. Every context chaining value and mode tag is 0. FSM is in IDLE.
- FSM states: IDLE -> LOAD -> EXPAND -> FINAL -> IDLE.
- IDLE: on start_i, the block is accepted when ctx_i<N_CTX, and (when new_i=1) opcode_i is legal for WORD_W. An accepted start:
  - latches ctx, mode and a cleared last flag;
  - loads the working state a..h and the chaining register from the IV (new_i=1, which also rewrites the context's mode tag) or from the stored context (new_i=0, which uses the stored mode tag and ignores opcode_i);
  - moves to LOAD.
  An illegal start is ignored and the FSM stays in IDLE.
- LOAD, rounds 0..15: data_ready_o=1. On each edge with data_valid_i=1, the engine stores the word in the 16-entry schedule buffer, executes one round with that word, ORs last_i into the last flag, and increments the round counter. With data_valid_i=0 the engine stalls and keeps its state. After round 15 it moves to EXPAND.
- EXPAND, rounds 16..R-1: data_ready_o=0. Each round uses the expanded word W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16] from the circular buffer. The engine does not stall.
- FINAL, one cycle: H_i = chain_i + state_i, all sums mod 2^WORD_W.
  - If the last flag is 0: write H to context[ctx]; done_o stays 0.
  - If the last flag is 1: drive hash_o with H and pulse done_o=1 with done_ctx_o=ctx, then clear context[ctx] chain and mode tag to 0.
  - In both cases move to IDLE.
- Truncation, applied at hash_o only:
  - SHA-224: hash_o[7]=0.
  - SHA-384: hash_o[6..7]=0.
  - SHA-512/256: hash_o[4..7]=0.
  - SHA-512/224: hash_o[3][31:0]=0 and hash_o[4..7]=0.
- hash_o holds its value until the next done_o.
- Latency with back-to-back data: start edge E0; rounds on E1..ER; FINAL on E(R+1). done_o and core_ready_o are high after E(R+1). That is 65 edges for WORD_W=32 and 81 edges for WORD_W=64.
- abort_i in LOAD, EXPAND or FINAL: the engine returns to IDLE on the next edge. No context write and no done_o. abort_i has priority over data and over the FINAL write. abort_i in IDLE has no effect.
- start_i while not IDLE is ignored.
- core_ready_o=1 only in IDLE.
- A continuation (new_i=0) on a context whose mode tag is 0 and whose chain is 0 is legal and hashes from a zero IV. Firmware must not do this.
- Asynchronous reset mid-block discards all contexts.

Test Plan:
1. WORD_W=32: new_i=1, opcode 0, ctx 0; words 0x61626380, 14x0, 0x00000018 with last_i=1 -> done_o after 65 edges; hash_o = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; done_ctx_o=0.
2. WORD_W=32, opcode 1, same "abc" block -> hash_o = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
3. Interleaving: block 1 of the 56-byte "abcdbcdecdef...nopq" message on ctx 2 (new_i=1, last_i=0), then "abc" on ctx 1, then block 2 on ctx 2 (new_i=0, last_i=1) -> "abc" digest with done_ctx_o=1, then 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1 with done_ctx_o=2.
4. WORD_W=64, opcode 0, padded "abc" (word0=0x6162638000000000, word15=0x18) -> done_o after 81 edges; hash_o[0]=ddaf35a193617aba, hash_o[7]=2a9ac94fa54ca49f. Repeat with opcode 1 -> hash_o[6..7]=0.
5. Stall and abort: drop data_valid_i for 5 cycles mid-LOAD -> same digest 5 cycles later. Abort at round 40 of a non-last block, then a continuation on that context -> chain unchanged and no done_o pulse.
6. Illegal starts: opcode 2 with WORD_W=32, or ctx_i>=N_CTX with N_CTX=3 -> core_ready_o stays 1 and data_ready_o stays 0. Reset mid-EXPAND -> all outputs return to reset values.
